// File: rtl/binary_graycode.sv
// Registered binary <-> reflected Gray code converter with one cycle of latency.
// Mode 0 encodes binary to Gray, mode 1 decodes Gray to binary; results are held while idle.
module binary_graycode #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             out_mode
);

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g;
        g[WIDTH-1] = b[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            g[i] = b[i+1] ^ b[i];
        end
        return g;
    endfunction

    // Decoding is a prefix XOR running down from the MSB
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] conv_s;
    logic [WIDTH-1:0] out_r;
    logic             out_valid_r;
    logic             out_mode_r;

    // Select the conversion for the current input word
    always_comb begin
        conv_s = {WIDTH{1'b0}};
        if (mode == 1'b1) begin
            conv_s = gray2bin(in);
        end else begin
            conv_s = bin2gray(in);
        end
    end

    // Capture a result only when qualified, so idle inputs never reach out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_mode_r  <= 1'b0;
        end else if (in_valid) begin
            out_r       <= conv_s;
            out_valid_r <= 1'b1;
            out_mode_r  <= mode;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign out_mode  = out_mode_r;

endmodule

// File: tb/tb_binary_graycode.sv
// Directed bench for binary_graycode: table-driven vectors, full 4-bit sweep and round trip,
// valid gating, asynchronous mid-stream reset and the 1-bit identity case.
module tb_binary_graycode;

    typedef struct {
        logic       mode;
        logic [3:0] in;
        logic [3:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       mode;
    logic [3:0] in;
    logic [3:0] out;
    logic       out_valid;
    logic       out_mode;

    logic       in_valid1;
    logic       mode1;
    logic [0:0] in1;
    logic [0:0] out1;
    logic       out_valid1;
    logic       out_mode1;

    int n_checks;
    int n_fail;

    vec_t       vecs[10];
    logic [3:0] gray_tab[16];
    logic [3:0] captured[16];

    binary_graycode #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .in(in),
        .out(out), .out_valid(out_valid), .out_mode(out_mode)
    );

    binary_graycode #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .mode(mode1), .in(in1),
        .out(out1), .out_valid(out_valid1), .out_mode(out_mode1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one input at the falling edge, then sample just after the next rising edge
    task automatic apply(input logic v, input logic m, input logic [3:0] d);
        @(negedge clk);
        in_valid = v;
        mode     = m;
        in       = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{1'b0, 4'h3, 4'h2};
        vecs[1] = '{1'b0, 4'hF, 4'h8};
        vecs[2] = '{1'b0, 4'h0, 4'h0};
        vecs[3] = '{1'b1, 4'h2, 4'h3};
        vecs[4] = '{1'b1, 4'h0, 4'h0};
        vecs[5] = '{1'b1, 4'h8, 4'hF};
        vecs[6] = '{1'b0, 4'h5, 4'h7};
        vecs[7] = '{1'b1, 4'h7, 4'h5};
        vecs[8] = '{1'b1, 4'hC, 4'h8};
        vecs[9] = '{1'b0, 4'h6, 4'h5};
        gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; in = 4'h0;
        in_valid1 = 1'b0; mode1 = 1'b0; in1 = 1'b0;
        #2;
        check("reset_out", 32'(out), 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_mode", 32'(out_mode), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors, back to back with mixed modes
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, vecs[i].mode, vecs[i].in);
            check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'h1);
            check($sformatf("vec%0d_mode", i), 32'(out_mode), 32'(vecs[i].mode));
        end

        // Full mode-0 sweep with single-bit-change property
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 1'b0, 4'(i));
            captured[i] = out;
            check($sformatf("sweep%0d", i), 32'(out), 32'(gray_tab[i]));
            if (i > 0)
                check($sformatf("step%0d", i), 32'($countones(captured[i] ^ captured[i-1])), 32'h1);
        end
        check("step_wrap", 32'($countones(captured[15] ^ captured[0])), 32'h1);

        // Round trip of the captured Gray words
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 1'b1, captured[i]);
            check($sformatf("round%0d", i), 32'(out), 32'(i));
            check($sformatf("round%0d_mode", i), 32'(out_mode), 32'h1);
        end

        // Valid gating, including unknown input during the gap
        apply(1'b1, 1'b0, 4'h3);
        check("gate1_out", 32'(out), 32'h2);
        check("gate1_valid", 32'(out_valid), 32'h1);
        apply(1'b0, 1'b1, 4'h5);
        check("gate2_out", 32'(out), 32'h2);
        check("gate2_valid", 32'(out_valid), 32'h0);
        check("gate2_mode", 32'(out_mode), 32'h0);
        apply(1'b0, 1'b0, 4'bxxxx);
        check("gatex_out", 32'(out), 32'h2);
        apply(1'b1, 1'b0, 4'h6);
        check("gate3_out", 32'(out), 32'h5);
        check("gate3_valid", 32'(out_valid), 32'h1);

        // Asynchronous reset between edges, then resume
        apply(1'b1, 1'b1, 4'hB);
        check("pre_rst_mode", 32'(out_mode), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midrst_out", 32'(out), 32'h0);
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_mode", 32'(out_mode), 32'h0);
        @(negedge clk);
        in_valid = 1'b1; mode = 1'b0; in = 4'h4;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_out", 32'(out), 32'h6);
        check("postrst_valid", 32'(out_valid), 32'h1);

        // One-bit datapath is the identity in both modes
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            in_valid1 = 1'b1;
            mode1     = i[1];
            in1       = i[0:0];
            @(posedge clk);
            #1;
            check($sformatf("w1_%0d", i), 32'(out1), 32'(i[0]));
            check($sformatf("w1_%0d_mode", i), 32'(out_mode1), 32'(i[1]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
